// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin merge of execute-unit writeback streams into one registered writeback port
module writeback_arbiter #(
  parameter int p_num_pipes    = 2,
  parameter int p_addr_bits    = 32,
  parameter int p_data_bits    = 32,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_pipes-1:0]                X_val,
  output logic [p_num_pipes-1:0]                X_rdy,
  input  logic [p_num_pipes*p_addr_bits-1:0]    X_pc,
  input  logic [p_num_pipes*p_seq_num_bits-1:0] X_seq_num,
  input  logic [p_num_pipes*5-1:0]              X_waddr,
  input  logic [p_num_pipes*p_data_bits-1:0]    X_wdata,
  input  logic [p_num_pipes-1:0]                X_wen,
  output logic                                  W_val,
  input  logic                                  W_rdy,
  output logic [p_addr_bits-1:0]                W_pc,
  output logic [p_seq_num_bits-1:0]             W_seq_num,
  output logic [4:0]                            W_waddr,
  output logic [p_data_bits-1:0]                W_wdata,
  output logic                                  W_wen
);
  localparam int iw = $clog2(p_num_pipes);
  logic [iw-1:0] ptr, gidx;
  logic found, can_accept;
  assign can_accept = !W_val || W_rdy;
  always_comb begin
    found = 1'b0;
    gidx = ptr;
    for (int k = 0; k < p_num_pipes; k++) begin
      if (!found && X_val[(int'(ptr) + k) % p_num_pipes]) begin
        found = 1'b1;
        gidx = iw'((int'(ptr) + k) % p_num_pipes);
      end
    end
    X_rdy = (found && can_accept && !rst) ? p_num_pipes'(1) << gidx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      W_val <= 1'b0;
      W_pc <= '0;
      W_seq_num <= '0;
      W_waddr <= '0;
      W_wdata <= '0;
      W_wen <= 1'b0;
      ptr <= '0;
    end else if (found && can_accept) begin
      W_val <= 1'b1;
      W_pc <= X_pc[gidx*p_addr_bits +: p_addr_bits];
      W_seq_num <= X_seq_num[gidx*p_seq_num_bits +: p_seq_num_bits];
      W_waddr <= X_waddr[gidx*5 +: 5];
      W_wdata <= X_wdata[gidx*p_data_bits +: p_data_bits];
      W_wen <= X_wen[gidx];
      ptr <= (gidx == iw'(p_num_pipes - 1)) ? '0 : gidx + 1'b1;
    end else if (W_rdy) begin
      W_val <= 1'b0;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: randomized and directed checks of writeback_arbiter against a queue-based reference model
module tb_writeback_arbiter;
  localparam int N = 2;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  seq;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
  } msg_t;
  logic clk = 1'b0, rst = 1'b1, W_rdy = 1'b0;
  logic [N-1:0] X_val = '0, X_rdy, gate = '1;
  logic [N*32-1:0] X_pc, X_wdata;
  logic [N*5-1:0] X_seq_num, X_waddr;
  logic [N-1:0] X_wen;
  logic W_val, W_wen;
  logic [31:0] W_pc, W_wdata;
  logic [4:0] W_seq_num, W_waddr;
  msg_t in_msg [N];
  msg_t q [N][$];
  msg_t got [$];
  msg_t m_out = '0;
  bit m_val = 1'b0;
  int m_ptr = 0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  for (genvar i = 0; i < N; i++) begin : g_pack
    assign X_pc[i*32 +: 32] = in_msg[i].pc;
    assign X_seq_num[i*5 +: 5] = in_msg[i].seq;
    assign X_waddr[i*5 +: 5] = in_msg[i].waddr;
    assign X_wdata[i*32 +: 32] = in_msg[i].wdata;
    assign X_wen[i] = in_msg[i].wen;
  end
  writeback_arbiter #(.p_num_pipes(N)) dut (
    .clk(clk), .rst(rst), .X_val(X_val), .X_rdy(X_rdy), .X_pc(X_pc), .X_seq_num(X_seq_num),
    .X_waddr(X_waddr), .X_wdata(X_wdata), .X_wen(X_wen), .W_val(W_val), .W_rdy(W_rdy),
    .W_pc(W_pc), .W_seq_num(W_seq_num), .W_waddr(W_waddr), .W_wdata(W_wdata), .W_wen(W_wen)
  );
  logic rst3 = 1'b1, w3_val, w3_wen;
  logic [2:0] v3 = '0, r3, wen3 = '0;
  logic [14:0] s3 = '0, a3 = '0;
  logic [95:0] pc3 = '0, d3 = '0;
  logic [31:0] w3_pc, w3_wdata;
  logic [4:0] w3_seq, w3_waddr;
  writeback_arbiter #(.p_num_pipes(3)) dut3 (
    .clk(clk), .rst(rst3), .X_val(v3), .X_rdy(r3), .X_pc(pc3), .X_seq_num(s3),
    .X_waddr(a3), .X_wdata(d3), .X_wen(wen3), .W_val(w3_val), .W_rdy(1'b1),
    .W_pc(w3_pc), .W_seq_num(w3_seq), .W_waddr(w3_waddr), .W_wdata(w3_wdata), .W_wen(w3_wen)
  );
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic msg_t mk(input logic [31:0] pc, input logic [4:0] seq, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic wen);
    msg_t m;
    m.pc = pc; m.seq = seq; m.waddr = waddr; m.wdata = wdata; m.wen = wen;
    return m;
  endfunction
  // first valid pipe at or after the round-robin pointer, or -1 when nothing may be accepted
  function automatic int exp_grant();
    if (m_val && !W_rdy) return -1;
    for (int k = 0; k < N; k++) if (X_val[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  // one cycle: present queue heads, check outputs against the model, advance model at the edge
  task automatic step();
    int g;
    for (int p = 0; p < N; p++) begin
      X_val[p] = gate[p] && q[p].size() > 0;
      in_msg[p] = q[p].size() > 0 ? q[p][0] : '0;
    end
    #1;
    g = rst ? -1 : exp_grant();
    check("x_rdy", X_rdy, g < 0 ? 0 : (1 << g));
    check("w_val", W_val, m_val);
    check("w_msg", {W_pc, W_seq_num, W_waddr, W_wdata, W_wen}, m_out);
    if (!rst && m_val && W_rdy) got.push_back(m_out);
    @(posedge clk);
    if (rst) begin
      m_val = 1'b0; m_ptr = 0; m_out = '0;
    end else if (g >= 0) begin
      m_val = 1'b1; m_out = q[g][0]; m_ptr = (g + 1) % N;
      void'(q[g].pop_front());
    end else if (W_rdy) m_val = 1'b0;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    got.delete();
  endtask
  initial begin
    int nxt [N];
    for (int p = 0; p < N; p++) in_msg[p] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;
    W_rdy = 1'b1;
    q[0].push_back(mk(32'd0, 5'd0, 5'd1, 32'd3, 1'b1));
    step();
    #1 check("single_out", {W_val, W_pc, W_seq_num, W_waddr, W_wdata, W_wen}, {1'b1, 32'd0, 5'd0, 5'd1, 32'd3, 1'b1});
    step();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      q[0].push_back(mk(32'h100 + k, 5'(2*k + 1), 5'd2, 32'hA0 + k, 1'b1));
      q[1].push_back(mk(32'h200 + k, 5'(2*k + 2), 5'd3, 32'hB0 + k, 1'b1));
    end
    repeat (7) step();
    check("cont_count", got.size(), 6);
    foreach (got[k]) check("cont_order", got[k].seq, k + 1);
    do_reset();
    q[0].push_back(mk(32'h300, 5'd7, 5'd4, 32'h77, 1'b1));
    step();
    W_rdy = 1'b0;
    q[0].push_back(mk(32'h301, 5'd9, 5'd5, 32'h99, 1'b0));
    q[1].push_back(mk(32'h400, 5'd8, 5'd6, 32'h88, 1'b1));
    repeat (3) step();
    #1 check("bp_hold", {W_val, W_seq_num}, {1'b1, 5'd7});
    W_rdy = 1'b1;
    step();
    #1 check("bp_next", W_seq_num, 8);
    repeat (2) step();
    q[0].push_back(mk(32'h500, 5'd4, 5'd7, 32'h44, 1'b1));
    step();
    got.delete();
    rst = 1'b1;
    W_rdy = 1'b0;
    step();
    rst = 1'b0;
    #1 check("rst_drop", W_val, 0);
    W_rdy = 1'b1;
    repeat (3) step();
    check("rst_never", got.size(), 0);
    do_reset();
    for (int p = 0; p < N; p++) begin
      nxt[p] = 0;
      for (int k = 0; k < 20; k++)
        q[p].push_back(mk({16'(p), 16'(k)}, 5'(k), 5'($urandom), $urandom, 1'($urandom)));
    end
    for (int c = 0; c < 3000 && got.size() < 2*20; c++) begin
      for (int p = 0; p < N; p++) gate[p] = $urandom_range(0, 2) != 0;
      W_rdy = $urandom_range(0, 2) != 0;
      step();
    end
    check("rand_count", got.size(), 2*20);
    foreach (got[k]) begin
      check("rand_order", got[k].pc[15:0], nxt[got[k].pc[31:16]]);
      nxt[got[k].pc[31:16]]++;
    end
    rst3 = 1'b0;
    s3[10 +: 5] = 5'd9;
    v3 = 3'b100;
    #1 check("wrap_rdy", r3, 3'b100);
    @(posedge clk);
    @(negedge clk);
    #1 check("wrap_out", {w3_val, w3_seq}, {1'b1, 5'd9});
    v3 = 3'b101;
    #1 check("wrap_ptr", r3, 3'b001);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
